part3_mac_pipe: RTL and testbench
=================================

// Module: part3_mac_pipe
// PURPOSE
//  Parametrised signed multiply-accumulate unit. It is the successor to the fixed 8x8->16 part2 MAC.
//  Adds configurable operand/accumulator widths, an optional multiplier pipeline stage,
//  a wrap/saturate overflow mode and a per-sample accumulator clear.
//  Sits in the neural-net datapath as the dot-product engine feeding the activation stage.
// PARAMETERS
//  WIDTH_IN   8   signed operand width of a, b
//  WIDTH_OUT  16  signed accumulator/output width; must be >= 2*WIDTH_IN (elaboration $error otherwise)
//  PIPE       0   0: no extra stage; 1: register the product (one extra cycle of latency)
//  SATURATE   0   0: two's-complement wrap on overflow; 1: clamp to max/min on overflow
// PORTS
//  clk        in   1          clock; all state updates on posedge
//  reset      in   1          synchronous, active-high
//  a          in   WIDTH_IN   signed multiplicand
//  b          in   WIDTH_IN   signed multiplier
//  valid_in   in   1          a/b/clear_acc are valid this cycle
//  clear_acc  in   1          with valid_in: this sample loads the accumulator instead of adding to it
//  f          out  WIDTH_OUT  signed accumulator value
//  valid_out  out  1          one-cycle pulse: f was updated on the last edge
//  overflow   out  1          sticky overflow flag
// BEHAVIOUR
//  - Reset: synchronous, active-high. All input/pipe/valid registers, f, valid_out and overflow go to 0.
//    In-flight samples are dropped. Reset has priority over every other event.
//  - Stage 0 (input register): a, b, valid_in and clear_acc are registered unconditionally every edge.
//  - Stage 1 (optional, PIPE=1 only): product = a_r*b_r, computed at full 2*WIDTH_IN width.
//    The product is registered together with its valid and clear flags.
//  - Accumulator stage (when valid is set at that stage):
//    - clear=1: f <= sign-extended product; overflow <= 0 (a load cannot overflow).
//    - clear=0: sum = f + sign-extended product, computed at WIDTH_OUT.
//  - Overflow: occurs when both operands have the same sign and the sum's sign differs from it.
//    - SATURATE=0: f <= wrapped sum.
//    - SATURATE=1: f <= 2^(WIDTH_OUT-1)-1 on positive overflow, -2^(WIDTH_OUT-1) on negative overflow.
//    - overflow <= overflow | ovf. It stays set until reset or a clear_acc sample.
//  - Accumulator stage, valid not set: f and overflow hold their values.
//  - valid_out <= stage valid. It is high exactly one cycle per accepted sample.
//  - Latency: a sample captured at edge k updates f and valid_out at edge k+1+PIPE.
//    Throughput is one sample per cycle; there is no backpressure.
//  - Back-to-back valid samples accumulate in order; gaps in valid_in leave f unchanged.
//  - clear_acc with valid_in=0 is ignored.
//  - Reset arriving while samples are in the pipe: the samples are lost, never emitted.
// TESTING (defaults unless noted; inputs driven 1 time unit after posedge)
//  1 Basic timing, reset released:
//    (1,1)v=0, (2,2)v=1, (3,3)v=1, (4,4)v=0, (5,5)v=0, (6,6)v=1
//    -> f/valid_out after successive edges: 0/0, 0/0, 4/1, 13/1, 13/0, 13/0, 49/1.
//  2 PIPE=1, same stimulus as test 1 -> identical f sequence, every update one cycle later;
//    valid_out is never high on two cycles for one sample.
//  3 Wrap mode: (127,127) x3 valid -> f = 16129, 32258, -17149, with overflow=1 on the third.
//    Then (1,1) -> f = -17148, overflow stays 1.
//  4 SATURATE=1: (127,127) x3 -> f = 16129, 32258, 32767, overflow=1.
//    Then (-1,1) -> f = 32766, overflow stays 1.
//    Negative case: (-128,127) x3 -> -16256, -32512, -32768.
//  5 Clear: after f=49, sample (3,-4) with clear_acc=1 -> f=-12, overflow=0.
//    Then (-128,-128) -> f=16372.
//  6 Reset mid-stream, PIPE=1: assert reset one cycle after a valid sample.
//    -> next edge f=0, valid_out=0, overflow=0; no late valid_out for the dropped sample.

Source files
------------

// File: rtl/part3_mac_pipe.sv
// Parametrised signed multiply-accumulate with optional product pipeline stage,
// wrap/saturate overflow handling and a per-sample accumulator load.
module part3_mac_pipe #(
    parameter int WIDTH_IN  = 8,
    parameter int WIDTH_OUT = 16,
    parameter int PIPE      = 0,
    parameter int SATURATE  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH_IN-1:0]  a,
    input  logic [WIDTH_IN-1:0]  b,
    input  logic                 valid_in,
    input  logic                 clear_acc,
    output logic [WIDTH_OUT-1:0] f,
    output logic                 valid_out,
    output logic                 overflow
);

    localparam int PW = 2 * WIDTH_IN;
    localparam logic [WIDTH_OUT-1:0] MAXV = {1'b0, {(WIDTH_OUT-1){1'b1}}};
    localparam logic [WIDTH_OUT-1:0] MINV = ~MAXV;

    generate
        if (WIDTH_OUT < PW) begin : g_width_check
            $error("part3_mac_pipe: WIDTH_OUT must be >= 2*WIDTH_IN");
        end
    endgenerate

    logic [WIDTH_IN-1:0] a_q, b_q;
    logic                vld0_q, clr0_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            vld0_q <= 1'b0;
            clr0_q <= 1'b0;
        end else begin
            a_q    <= a;
            b_q    <= b;
            vld0_q <= valid_in;
            clr0_q <= clear_acc;
        end
    end

    logic signed [PW-1:0] prod_s0;
    assign prod_s0 = PW'($signed(a_q)) * PW'($signed(b_q));

    logic signed [PW-1:0] prod_acc;
    logic                 vld_acc, clr_acc;

    generate
        if (PIPE != 0) begin : g_pipe
            logic signed [PW-1:0] prod_q;
            logic                 vld1_q, clr1_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    prod_q <= '0;
                    vld1_q <= 1'b0;
                    clr1_q <= 1'b0;
                end else begin
                    prod_q <= prod_s0;
                    vld1_q <= vld0_q;
                    clr1_q <= clr0_q;
                end
            end

            assign prod_acc = prod_q;
            assign vld_acc  = vld1_q;
            assign clr_acc  = clr1_q;
        end else begin : g_nopipe
            assign prod_acc = prod_s0;
            assign vld_acc  = vld0_q;
            assign clr_acc  = clr0_q;
        end
    endgenerate

    logic [WIDTH_OUT-1:0] f_q, f_d;
    logic                 vo_q;
    logic                 ov_q, ov_d;
    logic [WIDTH_OUT-1:0] ext, sum;
    logic                 ovf;

    assign ext = WIDTH_OUT'(prod_acc);
    assign sum = f_q + ext;
    // Same-sign operands whose sum flips sign; f_q's sign tells the overflow direction.
    assign ovf = (f_q[WIDTH_OUT-1] == ext[WIDTH_OUT-1]) &&
                 (sum[WIDTH_OUT-1] != f_q[WIDTH_OUT-1]);

    always_comb begin
        f_d  = f_q;
        ov_d = ov_q;
        if (vld_acc) begin
            if (clr_acc) begin
                f_d  = ext;
                ov_d = 1'b0;
            end else begin
                ov_d = ov_q | ovf;
                if (ovf && (SATURATE != 0)) begin
                    f_d = f_q[WIDTH_OUT-1] ? MINV : MAXV;
                end else begin
                    f_d = sum;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_q  <= '0;
            vo_q <= 1'b0;
            ov_q <= 1'b0;
        end else begin
            f_q  <= f_d;
            vo_q <= vld_acc;
            ov_q <= ov_d;
        end
    end

    assign f         = f_q;
    assign valid_out = vo_q;
    assign overflow  = ov_q;

endmodule

// File: tb/tb_part3_mac_pipe.sv
// Four MAC instances (PIPE x SATURATE) driven with common stimulus and checked
// against an edge-indexed arithmetic reference model.
module tb_part3_mac_pipe;

    localparam int NCFG = 4;
    localparam int MAXE = 4096;
    localparam longint MAXV = 32767;
    localparam longint MINV = -32768;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] a, b;
    logic       valid_in, clear_acc;
    logic [15:0] f_o [NCFG];
    logic        vo_o [NCFG];
    logic        ov_o [NCFG];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        part3_mac_pipe #(
            .WIDTH_IN (8),
            .WIDTH_OUT(16),
            .PIPE     (g % 2),
            .SATURATE (g / 2)
        ) dut (
            .clk      (clk),
            .reset    (reset),
            .a        (a),
            .b        (b),
            .valid_in (valid_in),
            .clear_acc(clear_acc),
            .f        (f_o[g]),
            .valid_out(vo_o[g]),
            .overflow (ov_o[g])
        );
    end

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    int  h_a [MAXE];
    int  h_b [MAXE];
    bit  h_v [MAXE];
    bit  h_c [MAXE];
    bit  h_r [MAXE];
    int  e = 0;

    longint m_acc [NCFG];
    bit     m_ov  [NCFG];

    task automatic check(input string tag, input longint got, input longint exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, e);
        end
    endtask

    // Apply one sample to the model: load on clear, else add with range-based overflow.
    task automatic model_apply(input int i, input longint p, input bit clr);
        longint s;
        if (clr) begin
            m_acc[i] = p;
            m_ov[i]  = 1'b0;
        end else begin
            s = m_acc[i] + p;
            if (s > MAXV) begin
                m_ov[i]  = 1'b1;
                m_acc[i] = (i / 2 != 0) ? MAXV : s - 65536;
            end else if (s < MINV) begin
                m_ov[i]  = 1'b1;
                m_acc[i] = (i / 2 != 0) ? MINV : s + 65536;
            end else begin
                m_acc[i] = s;
            end
        end
    endtask

    task automatic step(input int ai, input int bi, input bit vi, input bit ci, input bit ri);
        int  k;
        bit  ok;
        bit  vexp;
        a         = 8'(ai);
        b         = 8'(bi);
        valid_in  = vi;
        clear_acc = ci;
        reset     = ri;
        @(posedge clk);
        #1;
        h_a[e] = ai; h_b[e] = bi; h_v[e] = vi; h_c[e] = ci; h_r[e] = ri;
        for (int i = 0; i < NCFG; i++) begin
            vexp = 1'b0;
            if (h_r[e]) begin
                m_acc[i] = 0;
                m_ov[i]  = 1'b0;
            end else begin
                k = e - 1 - (i % 2);
                if (k >= 0 && h_v[k]) begin
                    ok = 1'b1;
                    for (int j = k; j < e; j++) if (h_r[j]) ok = 1'b0;
                    if (ok) begin
                        model_apply(i, longint'(h_a[k]) * longint'(h_b[k]), h_c[k]);
                        vexp = 1'b1;
                    end
                end
            end
            check($sformatf("f[%0d]", i), longint'($signed(f_o[i])), m_acc[i]);
            check($sformatf("valid_out[%0d]", i), longint'(vo_o[i]), longint'(vexp));
            check($sformatf("overflow[%0d]", i), longint'(ov_o[i]), longint'(m_ov[i]));
        end
        e++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int exp1_f [7] = '{0, 0, 4, 13, 13, 13, 49};
        int exp1_v [7] = '{0, 0, 1, 1, 0, 0, 1};
        int s1_a   [7] = '{1, 2, 3, 4, 5, 6, 0};
        bit s1_v   [7] = '{0, 1, 1, 0, 0, 1, 0};
        int ra, rb;
        bit rv, rc, rr;

        reset = 1'b1; a = '0; b = '0; valid_in = 1'b0; clear_acc = 1'b0;
        step(0, 0, 1'b0, 1'b0, 1'b1);
        step(0, 0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < NCFG; i++) begin
            check("reset_f", longint'($signed(f_o[i])), 0);
            check("reset_vo", longint'(vo_o[i]), 0);
        end

        // Basic timing (PIPE=0) and its one-cycle-later copy (PIPE=1).
        for (int j = 0; j < 7; j++) begin
            step(s1_a[j], s1_a[j], s1_v[j], 1'b0, 1'b0);
            check("t1_f_p0", longint'($signed(f_o[0])), exp1_f[j]);
            check("t1_vo_p0", longint'(vo_o[0]), exp1_v[j]);
            check("t2_f_p1", longint'($signed(f_o[1])), (j == 0) ? 0 : exp1_f[j-1]);
            check("t2_vo_p1", longint'(vo_o[1]), (j == 0) ? 0 : exp1_v[j-1]);
        end
        idle(1);
        check("t2_f_p1_end", longint'($signed(f_o[1])), 49);

        // Clear loads the product, then accumulates from there.
        step(3, -4, 1'b1, 1'b1, 1'b0);
        idle(1);
        check("t5_clear_f", longint'($signed(f_o[0])), -12);
        check("t5_clear_ov", longint'(ov_o[0]), 0);
        step(-128, -128, 1'b1, 1'b0, 1'b0);
        idle(1);
        check("t5_acc_f", longint'($signed(f_o[0])), 16372);

        // Wrap mode.
        step(0, 0, 1'b0, 1'b0, 1'b1);
        for (int j = 0; j < 3; j++) step(127, 127, 1'b1, 1'b0, 1'b0);
        step(1, 1, 1'b1, 1'b0, 1'b0);
        idle(2);
        check("t3_wrap_f_p0", longint'($signed(f_o[0])), -17148);
        check("t3_wrap_ov_p0", longint'(ov_o[0]), 1);
        check("t3_wrap_f_p1", longint'($signed(f_o[1])), -17148);

        // Saturate mode, positive then clear.
        step(0, 0, 1'b0, 1'b0, 1'b1);
        for (int j = 0; j < 3; j++) step(127, 127, 1'b1, 1'b0, 1'b0);
        step(-1, 1, 1'b1, 1'b0, 1'b0);
        idle(2);
        check("t4_sat_f_p0", longint'($signed(f_o[2])), 32766);
        check("t4_sat_ov_p0", longint'(ov_o[2]), 1);
        check("t4_sat_f_p1", longint'($signed(f_o[3])), 32766);
        step(3, -4, 1'b1, 1'b1, 1'b0);
        idle(2);
        check("t4_clr_f", longint'($signed(f_o[2])), -12);
        check("t4_clr_ov", longint'(ov_o[2]), 0);

        // Saturate mode, negative.
        step(0, 0, 1'b0, 1'b0, 1'b1);
        for (int j = 0; j < 3; j++) step(-128, 127, 1'b1, 1'b0, 1'b0);
        idle(2);
        check("t4_neg_sat_f", longint'($signed(f_o[2])), -32768);
        check("t4_neg_wrap_f", longint'($signed(f_o[0])), 16768);
        check("t4_neg_wrap_ov", longint'(ov_o[0]), 1);

        // Reset one cycle after a valid sample with PIPE=1: sample is lost.
        step(0, 0, 1'b0, 1'b0, 1'b1);
        step(5, 5, 1'b1, 1'b0, 1'b0);
        step(0, 0, 1'b0, 1'b0, 1'b1);
        check("t6_f", longint'($signed(f_o[1])), 0);
        check("t6_vo", longint'(vo_o[1]), 0);
        for (int j = 0; j < 3; j++) begin
            idle(1);
            check("t6_no_late_vo", longint'(vo_o[1]), 0);
        end

        // Randomized traffic, biased toward extreme operands to exercise overflow.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                ra = ($urandom_range(0, 1) != 0) ? 127 : -128;
                rb = ($urandom_range(0, 1) != 0) ? 127 : -128;
            end else begin
                ra = int'($urandom_range(0, 255)) - 128;
                rb = int'($urandom_range(0, 255)) - 128;
            end
            rv = ($urandom_range(0, 9) < 7);
            rc = ($urandom_range(0, 9) == 0);
            rr = ($urandom_range(0, 49) == 0);
            step(ra, rb, rv, rc, rr);
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
